// File: rtl/sump_cmd_sequencer.sv
// Byte-level SUMP command sequencer: frames 1-byte short and 5-byte long commands,
// emits one-cycle control pulses and holds sampler/trigger configuration registers.
module sump_cmd_sequencer #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        busy,
    output logic        cmd_reset,
    output logic        cmd_arm,
    output logic        cmd_id,
    output logic        cmd_meta,
    output logic        cmd_rle_finish,
    output logic        cmd_error,
    output logic [23:0] divider,
    output logic [15:0] read_count,
    output logic [15:0] delay_count,
    output logic [15:0] flags,
    output logic        trig_wr,
    output logic [1:0]  trig_stage,
    output logic [1:0]  trig_sel,
    output logic [31:0] trig_data
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ARG  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    opcode_q, opcode_d;
    logic [1:0]    idx_q, idx_d;
    logic [23:0]   arg_q, arg_d;
    logic          busy_op_q, busy_op_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic          cmd_reset_q, cmd_reset_d;
    logic          cmd_arm_q, cmd_arm_d;
    logic          cmd_id_q, cmd_id_d;
    logic          cmd_meta_q, cmd_meta_d;
    logic          cmd_rle_q, cmd_rle_d;
    logic          cmd_error_q, cmd_error_d;
    logic          trig_wr_q, trig_wr_d;
    logic [23:0]   divider_q, divider_d;
    logic [15:0]   read_count_q, read_count_d;
    logic [15:0]   delay_count_q, delay_count_d;
    logic [15:0]   flags_q, flags_d;
    logic [1:0]    trig_stage_q, trig_stage_d;
    logic [1:0]    trig_sel_q, trig_sel_d;
    logic [31:0]   trig_data_q, trig_data_d;
    logic [31:0]   value_s;

    // Long opcodes that perform a write; everything else is consumed silently.
    function automatic logic is_long_recognized(input logic [7:0] op);
        logic hit;
        if ((op == 8'h80) || (op == 8'h81) || (op == 8'h82)) begin
            hit = 1'b1;
        end else if ((op[7:4] == 4'hC) && (op[1:0] != 2'd3)) begin
            hit = 1'b1;
        end else begin
            hit = 1'b0;
        end
        return hit;
    endfunction

    assign value_s = {rx_data, arg_q};

    // Next-state, argument assembly, timeout and output decode.
    always_comb begin
        state_d       = state_q;
        opcode_d      = opcode_q;
        idx_d         = idx_q;
        arg_d         = arg_q;
        busy_op_d     = busy_op_q;
        tmo_d         = tmo_q;
        cmd_reset_d   = 1'b0;
        cmd_arm_d     = 1'b0;
        cmd_id_d      = 1'b0;
        cmd_meta_d    = 1'b0;
        cmd_rle_d     = 1'b0;
        cmd_error_d   = 1'b0;
        trig_wr_d     = 1'b0;
        divider_d     = divider_q;
        read_count_d  = read_count_q;
        delay_count_d = delay_count_q;
        flags_d       = flags_q;
        trig_stage_d  = trig_stage_q;
        trig_sel_d    = trig_sel_q;
        trig_data_d   = trig_data_q;

        case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    if (rx_data[7]) begin
                        opcode_d  = rx_data;
                        idx_d     = 2'd0;
                        busy_op_d = busy;
                        tmo_d     = '0;
                        state_d   = ST_ARG;
                    end else begin
                        case (rx_data)
                            8'h00:   cmd_reset_d = 1'b1;
                            8'h05:   cmd_rle_d   = 1'b1;
                            8'h01:   if (busy) cmd_error_d = 1'b1; else cmd_arm_d  = 1'b1;
                            8'h02:   if (busy) cmd_error_d = 1'b1; else cmd_id_d   = 1'b1;
                            8'h04:   if (busy) cmd_error_d = 1'b1; else cmd_meta_d = 1'b1;
                            default: cmd_error_d = 1'b0;
                        endcase
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARG: begin
                if (rx_valid) begin
                    tmo_d = '0;
                    if (idx_q == 2'd3) begin
                        state_d = ST_IDLE;
                        // Busy at opcode time drops the write but keeps the framing.
                        if (!is_long_recognized(opcode_q)) begin
                            cmd_error_d = 1'b0;
                        end else if (busy_op_q) begin
                            cmd_error_d = 1'b1;
                        end else begin
                            case (opcode_q)
                                8'h80: divider_d = value_s[23:0];
                                8'h81: begin
                                    read_count_d  = value_s[15:0];
                                    delay_count_d = value_s[31:16];
                                end
                                8'h82: flags_d = value_s[15:0];
                                default: begin
                                    trig_wr_d    = 1'b1;
                                    trig_stage_d = opcode_q[3:2];
                                    trig_sel_d   = opcode_q[1:0];
                                    trig_data_d  = value_s;
                                end
                            endcase
                        end
                    end else begin
                        arg_d = {rx_data, arg_q[23:8]};
                        idx_d = idx_q + 2'd1;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    cmd_error_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            opcode_q      <= 8'h00;
            idx_q         <= 2'd0;
            arg_q         <= 24'h000000;
            busy_op_q     <= 1'b0;
            tmo_q         <= '0;
            cmd_reset_q   <= 1'b0;
            cmd_arm_q     <= 1'b0;
            cmd_id_q      <= 1'b0;
            cmd_meta_q    <= 1'b0;
            cmd_rle_q     <= 1'b0;
            cmd_error_q   <= 1'b0;
            trig_wr_q     <= 1'b0;
            divider_q     <= 24'h000000;
            read_count_q  <= 16'h0000;
            delay_count_q <= 16'h0000;
            flags_q       <= 16'h0000;
            trig_stage_q  <= 2'd0;
            trig_sel_q    <= 2'd0;
            trig_data_q   <= 32'h00000000;
        end else begin
            state_q       <= state_d;
            opcode_q      <= opcode_d;
            idx_q         <= idx_d;
            arg_q         <= arg_d;
            busy_op_q     <= busy_op_d;
            tmo_q         <= tmo_d;
            cmd_reset_q   <= cmd_reset_d;
            cmd_arm_q     <= cmd_arm_d;
            cmd_id_q      <= cmd_id_d;
            cmd_meta_q    <= cmd_meta_d;
            cmd_rle_q     <= cmd_rle_d;
            cmd_error_q   <= cmd_error_d;
            trig_wr_q     <= trig_wr_d;
            divider_q     <= divider_d;
            read_count_q  <= read_count_d;
            delay_count_q <= delay_count_d;
            flags_q       <= flags_d;
            trig_stage_q  <= trig_stage_d;
            trig_sel_q    <= trig_sel_d;
            trig_data_q   <= trig_data_d;
        end
    end

    assign cmd_reset      = cmd_reset_q;
    assign cmd_arm        = cmd_arm_q;
    assign cmd_id         = cmd_id_q;
    assign cmd_meta       = cmd_meta_q;
    assign cmd_rle_finish = cmd_rle_q;
    assign cmd_error      = cmd_error_q;
    assign trig_wr        = trig_wr_q;
    assign divider        = divider_q;
    assign read_count     = read_count_q;
    assign delay_count    = delay_count_q;
    assign flags          = flags_q;
    assign trig_stage     = trig_stage_q;
    assign trig_sel       = trig_sel_q;
    assign trig_data      = trig_data_q;

endmodule

// File: tb/tb_sump_cmd_sequencer.sv
// Bench for sump_cmd_sequencer: directed command sequences then random byte traffic,
// every cycle compared against a queue-based reference model of the command rules.
module tb_sump_cmd_sequencer;

    localparam int T = 16;

    logic        clock = 1'b0;
    logic        reset, rx_valid, busy;
    logic [7:0]  rx_data;
    logic        cmd_reset, cmd_arm, cmd_id, cmd_meta, cmd_rle_finish, cmd_error, trig_wr;
    logic [23:0] divider;
    logic [15:0] read_count, delay_count, flags;
    logic [1:0]  trig_stage, trig_sel;
    logic [31:0] trig_data;

    sump_cmd_sequencer #(.TIMEOUT_CYCLES(T)) dut (
        .clock(clock), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy),
        .cmd_reset(cmd_reset), .cmd_arm(cmd_arm), .cmd_id(cmd_id), .cmd_meta(cmd_meta),
        .cmd_rle_finish(cmd_rle_finish), .cmd_error(cmd_error),
        .divider(divider), .read_count(read_count), .delay_count(delay_count), .flags(flags),
        .trig_wr(trig_wr), .trig_stage(trig_stage), .trig_sel(trig_sel), .trig_data(trig_data)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;

    // Reference model: pending long-command bytes, idle cycles since the last byte,
    // and the expected outputs for the cycle after the current edge.
    logic [7:0]  mq[$];
    logic        m_busy_op;
    int          m_idle;
    logic [6:0]  e_p;   // {reset, arm, id, meta, rle, error, trig_wr}
    logic [23:0] e_div;
    logic [15:0] e_rc, e_dc, e_fl;
    logic [1:0]  e_st, e_sel;
    logic [31:0] e_td;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic v, input logic [7:0] d, input logic b);
        logic [7:0]  op;
        logic [31:0] val;
        logic        rec;
        e_p = 7'b0;
        if (r) begin
            mq.delete();
            m_idle = 0; m_busy_op = 1'b0;
            e_div = '0; e_rc = '0; e_dc = '0; e_fl = '0; e_st = '0; e_sel = '0; e_td = '0;
        end else if (v) begin
            if (mq.size() == 0) begin
                if (d[7] == 1'b0) begin
                    if (d == 8'h00) e_p[6] = 1'b1;
                    else if (d == 8'h05) e_p[2] = 1'b1;
                    else if (d == 8'h01) begin if (b) e_p[1] = 1'b1; else e_p[5] = 1'b1; end
                    else if (d == 8'h02) begin if (b) e_p[1] = 1'b1; else e_p[4] = 1'b1; end
                    else if (d == 8'h04) begin if (b) e_p[1] = 1'b1; else e_p[3] = 1'b1; end
                end else begin
                    mq.push_back(d);
                    m_busy_op = b;
                    m_idle = 0;
                end
            end else begin
                mq.push_back(d);
                m_idle = 0;
                if (mq.size() == 5) begin
                    op  = mq[0];
                    val = {mq[4], mq[3], mq[2], mq[1]};
                    rec = (op == 8'h80) || (op == 8'h81) || (op == 8'h82) ||
                          ((op >= 8'hC0) && (op <= 8'hCF) && (op % 4 != 3));
                    mq.delete();
                    if (rec && m_busy_op) e_p[1] = 1'b1;
                    else if (rec) begin
                        if (op == 8'h80) e_div = val[23:0];
                        else if (op == 8'h81) begin e_rc = val[15:0]; e_dc = val[31:16]; end
                        else if (op == 8'h82) e_fl = val[15:0];
                        else begin
                            e_p[0] = 1'b1;
                            e_st   = 2'((op - 8'hC0) / 4);
                            e_sel  = 2'(op % 4);
                            e_td   = val;
                        end
                    end
                end
            end
        end else if (mq.size() != 0) begin
            m_idle++;
            if (m_idle == T) begin
                e_p[1] = 1'b1;
                mq.delete();
            end
        end
    endtask

    task automatic check_all();
        logic [6:0] p;
        p = {cmd_reset, cmd_arm, cmd_id, cmd_meta, cmd_rle_finish, cmd_error, trig_wr};
        chk("pulses", {25'd0, p}, {25'd0, e_p});
        chk("onehot", {31'd0, ($countones(p) <= 1)}, 32'd1);
        chk("divider", {8'd0, divider}, {8'd0, e_div});
        chk("read_count", {16'd0, read_count}, {16'd0, e_rc});
        chk("delay_count", {16'd0, delay_count}, {16'd0, e_dc});
        chk("flags", {16'd0, flags}, {16'd0, e_fl});
        chk("trig_stage_sel", {28'd0, trig_stage, trig_sel}, {28'd0, e_st, e_sel});
        chk("trig_data", trig_data, e_td);
    endtask

    task automatic cyc(input logic r, input logic v, input logic [7:0] d, input logic b);
        reset = r; rx_valid = v; rx_data = d; busy = b;
        model_step(r, v, d, b);
        @(posedge clock);
        #1;
        check_all();
    endtask

    task automatic send(input logic [7:0] d, input logic b);
        cyc(1'b0, 1'b1, d, b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; busy = 1'b0;
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        // short commands, 0x7F ignored
        send(8'h00, 1'b0); send(8'h02, 1'b0); send(8'h7F, 1'b0); idle(2);
        // read/delay count with zero data bytes
        send(8'h81, 1'b0); send(8'h0F, 1'b0); send(8'h00, 1'b0); send(8'h0F, 1'b0); send(8'h00, 1'b0);
        idle(1);
        // trigger write, then reserved trigger slot
        send(8'hC6, 1'b0); send(8'h40, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h08, 1'b0);
        send(8'hC3, 1'b0); send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b0);
        idle(1);
        // busy gating
        send(8'h01, 1'b1); send(8'h05, 1'b1);
        send(8'h80, 1'b1); send(8'h02, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0);
        idle(1);
        // timeout, then recovery
        send(8'h80, 1'b0); send(8'h03, 1'b0); idle(T + 2);
        send(8'h02, 1'b0);
        // byte on the expiring cycle keeps the command alive
        send(8'h80, 1'b0); send(8'h03, 1'b0); idle(T - 1);
        send(8'h04, 1'b0); send(8'h05, 1'b0); send(8'h06, 1'b0); idle(1);
        // port reset mid-command
        send(8'h82, 1'b0); send(8'hAA, 1'b0); send(8'hBB, 1'b0);
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        send(8'h82, 1'b0); send(8'h00, 1'b0); send(8'h08, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0);
        idle(1);
        // random traffic
        for (int n = 0; n < 4000; n++) begin
            logic [7:0] d;
            int sel;
            sel = int'($urandom_range(0, 9));
            case (sel)
                0, 1:    d = 8'($urandom_range(0, 5));
                2:       d = 8'h7F;
                3, 4:    d = 8'($urandom_range(8'h80, 8'h83));
                5, 6:    d = 8'($urandom_range(8'hC0, 8'hCF));
                default: d = 8'($urandom);
            endcase
            if ($urandom_range(0, 299) == 0) cyc(1'b1, 1'b0, 8'h00, 1'b0);
            else if ($urandom_range(0, 59) == 0) idle(int'($urandom_range(T - 2, T + 2)));
            else cyc(1'b0, ($urandom_range(0, 9) < 7), d, ($urandom_range(0, 4) == 0));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sump_cmd_sequencer.md
# sump_cmd_sequencer

Byte-level command sequencer for the logic analyzer. Parses the host command stream, delivered one byte at a time by the SPI or UART receiver, into 1-byte short commands and 5-byte long commands. Drives the control pulses (reset, arm, ID, metadata, RLE finish), holds the sampler configuration registers (divider, read/delay count, flags), and issues trigger-stage write strobes. Sits between the comm receiver and the sampler/trigger/controller blocks.

## Interface
Parameters:
- TIMEOUT_CYCLES, 100000: idle cycles allowed between bytes of a long command before the partial command is discarded; must be ≥ 2.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_valid  in  1  rx_data holds a new byte this cycle (one-cycle qualifier)
- rx_data  in  8  received byte
- busy  in  1  capture in progress (armed or reading out)
- cmd_reset  out  1  one-cycle pulse, opcode 0x00
- cmd_arm  out  1  one-cycle pulse, opcode 0x01
- cmd_id  out  1  one-cycle pulse, opcode 0x02
- cmd_meta  out  1  one-cycle pulse, opcode 0x04
- cmd_rle_finish  out  1  one-cycle pulse, opcode 0x05
- cmd_error  out  1  one-cycle pulse: dropped command or long-command timeout
- divider  out  24  sample divider, from opcode 0x80
- read_count  out  16  from opcode 0x81, value[15:0]
- delay_count  out  16  from opcode 0x81, value[31:16]
- flags  out  16  from opcode 0x82, value[15:0]
- trig_wr  out  1  one-cycle trigger register write strobe
- trig_stage  out  2  trigger stage, = opcode[3:2]
- trig_sel  out  2  0 = mask, 1 = value, 2 = config; = opcode[1:0]
- trig_data  out  32  trigger write data

## Operation
- Every output resets to 0.
- A byte is accepted on any cycle where rx_valid = 1. There is no backpressure.
- State IDLE, byte with bit 7 = 0 (short command):
  - 0x00 → cmd_reset.
  - 0x01 → cmd_arm.
  - 0x02 → cmd_id.
  - 0x04 → cmd_meta.
  - 0x05 → cmd_rle_finish.
  - Any other value (including 0x7F readout poll) is ignored silently; no cmd_error.
- State IDLE, byte with bit 7 = 1: latch the opcode, clear the argument byte index to 0, enter ARG.
- State ARG: four data bytes, little-endian, assembled as value[7:0], [15:8], [23:16], [31:24]. A data byte equal to 0x00 is data, not a reset. After the 4th byte, execute and return to IDLE.
- Long-command execution:
  - 0x80 → divider = value[23:0].
  - 0x81 → read_count, delay_count.
  - 0x82 → flags.
  - 0xC0–0xCF with opcode[1:0] ≠ 3 → trig_wr pulse; trig_stage, trig_sel and trig_data are valid during the pulse and held afterward.
  - 0xC3/C7/CB/CF and all other long opcodes are consumed and ignored silently.
- Busy gating:
  - With busy = 1, short 0x00 and 0x05 still execute.
  - Short 0x01, 0x02 and 0x04 are dropped and pulse cmd_error.
  - A recognized long opcode (0x80–0x82, 0xC0–0xCF with opcode[1:0] ≠ 3) is still fully consumed, to keep framing. It writes nothing and pulses cmd_error at completion.
  - busy is sampled on the cycle the opcode byte is accepted.
- Timeout:
  - In ARG, a counter clears on each accepted byte and increments on every other cycle.
  - When it reaches TIMEOUT_CYCLES, return to IDLE, discard the partial command, and pulse cmd_error.
  - If a byte arrives on the cycle the counter would expire, the byte is accepted and the timeout does not fire.
- The cmd_reset pulse does not clear the configuration registers; only the reset port does.
- Port reset mid-command returns to IDLE immediately and discards the partial command.

## Timing
- Short command: pulse asserts the cycle after the accepting edge; width exactly 1 cycle.
- Long command:
  - Configuration registers update, and trig_wr/cmd_error pulse, the cycle after the 4th data byte is accepted.
  - Registers are never partially updated.
- Back-to-back bytes on consecutive cycles are supported with no lost bytes. Throughput is 1 byte/cycle.
- At most one of the pulse outputs (cmd_*, trig_wr, cmd_error) is high in any cycle. The only exception is that cmd_error may not coincide with trig_wr, which cannot occur by construction.
- A timeout fires exactly TIMEOUT_CYCLES cycles after the last accepted byte.

## Test plan
- Reset, then bytes 0x00, 0x02, 0x7F on consecutive cycles → cmd_reset, then cmd_id, each 1 cycle; nothing on 0x7F; all config outputs still 0.
- 0x81, 0x0F, 0x00, 0x0F, 0x00 → read_count = 0x000F and delay_count = 0x000F, one cycle after the last byte; cmd_reset never pulses on the 0x00 data bytes.
- 0xC6, 0x40, 0x00, 0x00, 0x08 → single trig_wr with trig_stage = 1, trig_sel = 2, trig_data = 0x08000040; 0xC3 + 4 bytes → no strobe and no error.
- busy = 1, then 0x01, 0x05, then 0x80 + 02 00 00 00 → cmd_error, then cmd_rle_finish, then cmd_error; divider unchanged at 0.
- TIMEOUT_CYCLES = 16: 0x80, 0x03, then 16 idle cycles → cmd_error, back in IDLE; next 0x02 → cmd_id. Repeat with a byte arriving on the expiring cycle → no error, parse continues.
- Assert reset after 0x82 + 2 bytes, then send 0x82, 0x00, 0x08, 0x00, 0x00 → flags = 0x0800, with no residue from the aborted command.
